time_set_core: RTL and testbench
================================

Name: time_set_core

Overview:
- Consumer of the button-control strobes (adjust, select, add, clr, adjust_week, add_week).
- Holds the running BCD time HH:MM:SS and the weekday.
- Advances the time once per second in run mode.
- Applies per-digit edits in adjust mode and provides a per-digit blink mask to the display drivers.

Parameters:
TICK_DIV, 50000000, CLOCK_50 cycles per 1 s tick (min 2)
BLINK_DIV, 12500000, CLOCK_50 cycles per blink phase toggle (min 1)

Ports:
CLOCK_50  input  1  system clock, all logic on posedge
rst  input  1  reset, synchronous, active-high
adjust  input  1  1 = run (time counts), 0 = adjust mode (digit editing)
select  input  4  digit index in adjust mode
add  input  1  increment strobe; acts on rising edge
clr  input  1  clear strobe; level-active
adjust_week  input  1  1 = weekday editing enabled
add_week  input  1  weekday increment; acts on rising edge
sec  output  8  BCD seconds {tens,ones}
min  output  8  BCD minutes
hour  output  8  BCD hours
week  output  3  weekday 0..6
tick_1hz  output  1  one-cycle pulse on each counted second
blink_mask  output  6  bit n = 1 blanks digit n (bit order matches select)

Behaviour:
- Reset (rst=1 at a clock edge):
  - sec, min and hour = 8'h00; week = 0.
  - tick_1hz = 0; blink_mask = 0.
  - Prescaler, blink counter and blink phase = 0.
  - Edge registers add_d and add_week_d = 0.
  - rst overrides all other inputs in that cycle.
- Edge detection:
  - add_rise = add & ~add_d, where add_d is add registered on the previous cycle.
  - add_week_rise is formed the same way from add_week.
  - The edge registers update every cycle, in every mode.
- Digit map (select value -> digit, increment range):
  - 0: sec ones, 0..9
  - 1: sec tens, 0..5
  - 2: min ones, 0..9
  - 3: min tens, 0..5
  - 4: hour ones, 0..9, or 0..3 when hour tens = 2
  - 5: hour tens, 0..2
  - 6..15: no digit; add and clr have no effect.
- Run mode (adjust=1):
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On the cycle prescaler = TICK_DIV-1: tick_1hz=1 for that one registered cycle, and the time advances by 1 s in the same edge.
  - Carry chain: sec ones 9 -> sec tens; 59 s -> min+1; 59 min -> hour+1.
  - 23:59:59 -> 00:00:00 and week = (week+1) mod 7.
  - add and clr are ignored. blink_mask = 0; blink counter and phase are held at 0.
- Adjust mode (adjust=0):
  - Prescaler held at 0 and tick_1hz = 0, so the first run second after leaving adjust is a full TICK_DIV.
  - clr=1 with a valid select: the selected digit is set to 0 on every cycle clr is high.
  - add_rise with a valid select and clr=0: the selected digit increments and wraps to 0 at the top of its range. There is no carry into the neighbouring digit.
  - clr has priority over add_rise in the same cycle.
  - Hour tens incremented 1 -> 2 while hour ones > 3: hour ones is forced to 3 in the same edge, so hours never exceed 23.
  - Hour tens wraps 2 -> 0.
  - Blink counter counts 0..BLINK_DIV-1; at the wrap the phase toggles.
  - blink_mask = phase << select when select < 6, else 0. The mask is registered with 1-cycle latency.
- Weekday:
  - With adjust_week=1, each add_week_rise sets week = (week+1) mod 7; 6 -> 0.
  - This is independent of adjust, and time keeps counting.
  - If a midnight rollover and an add_week_rise occur on the same edge, week = (week+2) mod 7.
  - add_week_rise with adjust_week=0 is ignored.
- Mode changes:
  - A mode change mid-second discards the partial prescaler count.
  - Digits are never left out of range: all edits and carries keep valid BCD.
- Latency: every output is registered; an input sampled at edge k is visible after edge k.

Test Plan:
- TICK_DIV=4: release reset with adjust=1 for 12 cycles -> tick_1hz pulses on cycles 4, 8 and 12 (1-based after reset); sec = 8'h03.
- Preload 23:59:58 via adjust-mode edits, week=6, then run 2 ticks -> 23:59:59, then 00:00:00 with week=0 on the same edge as the second tick.
- adjust=0, select=1, sec tens=5: one add pulse -> sec tens = 0, min unchanged.
- adjust=0, hour=19, select=5: one add pulse -> hour = 8'h23 (ones clamped to 3); a second add -> 8'h03.
- adjust=0, select=2, add and clr rising together with min=8'h47 -> min=8'h40. select=9 with an add pulse -> no digit changes.
- BLINK_DIV=2, adjust=0, select=3 -> blink_mask toggles 6'b000000 / 6'b001000 every 2 cycles. adjust=1 -> mask = 0 on the next cycle.

Source files
------------

// File: rtl/time_set_core.sv
// BCD time-of-day and weekday keeper: counts seconds in run mode, applies
// per-digit edits in adjust mode and drives the digit blink mask.
module time_set_core #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       adjust,
  input  logic [3:0] select,
  input  logic       add,
  input  logic       clr,
  input  logic       adjust_week,
  input  logic       add_week,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [2:0] week,
  output logic       tick_1hz,
  output logic [5:0] blink_mask
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          add_d, add_week_d;
  logic          add_rise, add_week_rise;
  logic          tick_now, midnight, week_inc;
  logic [7:0]    sec_n, min_n, hour_n;
  logic [2:0]    week_n;
  logic [3:0]    week_sum;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] top);
    return (v >= top) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
    else                     return 8'h00;
  endfunction

  assign add_rise      = add & ~add_d;
  assign add_week_rise = add_week & ~add_week_d;
  assign tick_now      = adjust && (presc == TICK_LAST);
  assign week_inc      = adjust_week && add_week_rise;

  always_comb begin
    sec_n    = sec;
    min_n    = min;
    hour_n   = hour;
    midnight = 1'b0;
    if (tick_now) begin
      sec_n = bcd_inc60(sec);
      if (sec == 8'h59) begin
        min_n = bcd_inc60(min);
        if (min == 8'h59) begin
          if (hour == 8'h23) begin
            hour_n   = 8'h00;
            midnight = 1'b1;
          end else if (hour[3:0] == 4'd9) begin
            hour_n = {hour[7:4] + 4'd1, 4'd0};
          end else begin
            hour_n = {hour[7:4], hour[3:0] + 4'd1};
          end
        end
      end
    end else if (!adjust && (select < 4'd6) && (clr || add_rise)) begin
      // clr wins over add; edits never carry into the neighbouring digit
      case (select)
        4'd0: sec_n[3:0]  = clr ? 4'd0 : wrap_inc(sec[3:0], 4'd9);
        4'd1: sec_n[7:4]  = clr ? 4'd0 : wrap_inc(sec[7:4], 4'd5);
        4'd2: min_n[3:0]  = clr ? 4'd0 : wrap_inc(min[3:0], 4'd9);
        4'd3: min_n[7:4]  = clr ? 4'd0 : wrap_inc(min[7:4], 4'd5);
        4'd4: hour_n[3:0] = clr ? 4'd0 :
                            wrap_inc(hour[3:0], (hour[7:4] == 4'd2) ? 4'd3 : 4'd9);
        4'd5: begin
          if (clr || hour[7:4] == 4'd2) begin
            hour_n[7:4] = 4'd0;
          end else begin
            hour_n[7:4] = hour[7:4] + 4'd1;
            // entering the 20s must not leave hours above 23
            if (hour[7:4] == 4'd1 && hour[3:0] > 4'd3) hour_n[3:0] = 4'd3;
          end
        end
        default: ;
      endcase
    end
    week_sum = {1'b0, week} + {3'b000, midnight} + {3'b000, week_inc};
    week_n   = (week_sum >= 4'd7) ? 3'(week_sum - 4'd7) : week_sum[2:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sec         <= 8'h00;
      min         <= 8'h00;
      hour        <= 8'h00;
      week        <= 3'd0;
      tick_1hz    <= 1'b0;
      blink_mask  <= 6'd0;
      presc       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      add_d       <= 1'b0;
      add_week_d  <= 1'b0;
    end else begin
      add_d      <= add;
      add_week_d <= add_week;
      sec        <= sec_n;
      min        <= min_n;
      hour       <= hour_n;
      week       <= week_n;
      tick_1hz   <= tick_now;
      if (adjust) begin
        presc       <= tick_now ? '0 : presc + PW'(1);
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
        blink_mask  <= 6'd0;
      end else begin
        // partial second is discarded so the next run second is full length
        presc <= '0;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
        blink_mask <= (select < 4'd6) ? (6'(blink_phase) << select) : 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_time_set_core.sv
// Directed bench for time_set_core with short tick and blink dividers.
module tb_time_set_core;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic       adjust = 1'b1;
  logic [3:0] select = 4'd0;
  logic       add = 1'b0;
  logic       clr = 1'b0;
  logic       adjust_week = 1'b0;
  logic       add_week = 1'b0;
  logic [7:0] sec, min, hour;
  logic [2:0] week;
  logic       tick_1hz;
  logic [5:0] blink_mask;

  int n_cmp = 0;
  int n_err = 0;

  time_set_core #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .adjust(adjust), .select(select),
    .add(add), .clr(clr), .adjust_week(adjust_week), .add_week(add_week),
    .sec(sec), .min(min), .hour(hour), .week(week),
    .tick_1hz(tick_1hz), .blink_mask(blink_mask)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic add_n(input logic [3:0] sel, input int n);
    select = sel;
    for (int i = 0; i < n; i++) begin
      add = 1'b1; step();
      add = 1'b0; step();
    end
  endtask

  task automatic clr_digit(input logic [3:0] sel);
    select = sel;
    clr = 1'b1; step();
    clr = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check_val("rst_sec", sec, 8'h00);
    check_val("rst_week", week, 3'd0);
    check_val("rst_tick", tick_1hz, 1'b0);
    check_val("rst_mask", blink_mask, 6'd0);

    // run from reset: tick on cycles 4, 8, 12
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val($sformatf("tick_c%0d", k), tick_1hz, (k % 4 == 0) ? 1 : 0);
    end
    check_val("run_sec", sec, 8'h03);

    // preload 23:59:58, week 6
    adjust = 1'b0;
    for (int d = 0; d < 6; d++) clr_digit(4'(d));
    add_n(4'd5, 2);
    add_n(4'd4, 3);
    add_n(4'd3, 5);
    add_n(4'd2, 9);
    add_n(4'd1, 5);
    add_n(4'd0, 8);
    adjust_week = 1'b1;
    for (int i = 0; i < 6; i++) begin
      add_week = 1'b1; step();
      add_week = 1'b0; step();
    end
    check_val("pre_time", {hour, min, sec}, 24'h235958);
    check_val("pre_week", week, 3'd6);

    adjust = 1'b1;
    adjust_week = 1'b0;
    repeat (4) step();
    check_val("t1_time", {hour, min, sec}, 24'h235959);
    check_val("t1_tick", tick_1hz, 1'b1);
    repeat (3) step();
    check_val("t2_pre_tick", tick_1hz, 1'b0);
    step();
    check_val("mid_time", {hour, min, sec}, 24'h000000);
    check_val("mid_week", week, 3'd0);
    check_val("mid_tick", tick_1hz, 1'b1);

    // sec tens wraps 5 -> 0 without carry
    adjust = 1'b0;
    add_n(4'd1, 5);
    check_val("sec50", sec, 8'h50);
    add_n(4'd1, 1);
    check_val("sec_tens_wrap", sec, 8'h00);
    check_val("sec_no_carry", min, 8'h00);

    // hour tens clamp and wrap
    add_n(4'd5, 1);
    add_n(4'd4, 9);
    check_val("hour19", hour, 8'h19);
    add_n(4'd5, 1);
    check_val("hour_clamp", hour, 8'h23);
    add_n(4'd5, 1);
    check_val("hour_tens_wrap", hour, 8'h03);

    // clr beats add; invalid select does nothing
    add_n(4'd3, 4);
    add_n(4'd2, 7);
    check_val("min47", min, 8'h47);
    select = 4'd2;
    add = 1'b1; clr = 1'b1; step();
    add = 1'b0; clr = 1'b0; step();
    check_val("clr_prio", min, 8'h40);
    add_n(4'd9, 1);
    check_val("sel9_noop", {hour, min, sec}, 24'h034000);

    // add_week ignored when weekday editing is off
    add_week = 1'b1; step();
    add_week = 1'b0; step();
    check_val("week_ignored", week, 3'd0);

    // midnight plus weekday edit on the same edge gives +2
    add_n(4'd5, 2);
    add_n(4'd3, 1);
    add_n(4'd2, 9);
    add_n(4'd1, 5);
    add_n(4'd0, 9);
    check_val("pre2_time", {hour, min, sec}, 24'h235959);
    adjust = 1'b1;
    adjust_week = 1'b1;
    repeat (3) step();
    add_week = 1'b1; step();
    add_week = 1'b0;
    check_val("mid2_time", {hour, min, sec}, 24'h000000);
    check_val("mid2_week", week, 3'd2);
    adjust_week = 1'b0;

    // blink pattern on min tens
    select = 4'd3;
    adjust = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_val($sformatf("blink_c%0d", k), blink_mask, (((k - 1) / 2) % 2 == 1) ? 6'b001000 : 6'b000000);
    end
    adjust = 1'b1;
    step();
    check_val("blink_off", blink_mask, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
